// File: rtl/key_press_classifier.sv
// Turns the debounced key level into single-cycle press, release, short-press,
// long-press and auto-repeat events, and keeps a wrapping count of short presses.
module key_press_classifier #(
  parameter logic [31:0] LONG_CNT   = 32'd99_999_999,
  parameter logic [31:0] REPEAT_CNT = 32'd19_999_999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t      state_reg;
  logic        key_d_reg;
  logic [31:0] hold_cnt_reg;
  logic [31:0] rep_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // key_d resets high so a key held through reset needs a release first
      state_reg     <= IDLE;
      key_d_reg     <= 1'b1;
      hold_cnt_reg  <= '0;
      rep_cnt_reg   <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= '0;
    end else begin
      key_d_reg     <= key_level;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (key_level && !key_d_reg) begin
            state_reg    <= PRESSED;
            hold_cnt_reg <= '0;
            press_pulse  <= 1'b1;
            held         <= 1'b1;
          end
        end

        PRESSED: begin
          // release is checked first so a release on the threshold cycle is short
          if (!key_level) begin
            state_reg     <= IDLE;
            release_pulse <= 1'b1;
            short_press   <= 1'b1;
            press_count   <= press_count + 8'd1;
            held          <= 1'b0;
          end else if (hold_cnt_reg == LONG_CNT - 32'd1) begin
            state_reg   <= LONG;
            long_press  <= 1'b1;
            rep_cnt_reg <= '0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 32'd1;
          end
        end

        LONG: begin
          if (!key_level) begin
            state_reg     <= IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if ((REPEAT_CNT != 32'd0) && (rep_cnt_reg == REPEAT_CNT - 32'd1)) begin
            repeat_pulse <= 1'b1;
            rep_cnt_reg  <= '0;
          end else if (rep_cnt_reg != 32'hFFFF_FFFF) begin
            rep_cnt_reg <= rep_cnt_reg + 32'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          held      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier: a vector table, directed multi-cycle sequences
// and random key activity, all checked against an elapsed-time event model.
module tb_key_press_classifier;

  localparam int L = 10;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_level = 1'b0;
  logic       press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;
  logic [7:0] press_count;

  key_press_classifier #(
    .LONG_CNT  (32'd10),
    .REPEAT_CNT(32'd4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       p;
    logic       rl;
    logic       sh;
    logic       lg;
    logic       rp;
    logic       hd;
    logic [7:0] cnt;
  } outs_t;

  typedef struct {
    bit    rst_n;
    bit    key;
    outs_t exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Model state: whether a press is in progress and how many edges since E0.
  bit         m_prev    = 1'b1;
  bit         m_pressed = 1'b0;
  int         m_age     = 0;
  logic [7:0] m_cnt     = 8'd0;
  outs_t      m_exp;

  int obs_press, obs_rel, obs_short, obs_long, obs_rep;

  function automatic outs_t dut_outs();
    outs_t o;
    o.p   = press_pulse;
    o.rl  = release_pulse;
    o.sh  = short_press;
    o.lg  = long_press;
    o.rp  = repeat_pulse;
    o.hd  = held;
    o.cnt = press_count;
    return o;
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got p/rl/sh/lg/rp/hd=%b cnt=%0d, expected p/rl/sh/lg/rp/hd=%b cnt=%0d",
               name, act[13:8], act[7:0], exp[13:8], exp[7:0]);
    end
  endtask

  task automatic model_edge(input bit r, input bit k);
    m_exp = '0;
    if (!r) begin
      m_prev    = 1'b1;
      m_pressed = 1'b0;
      m_age     = 0;
      m_cnt     = 8'd0;
    end else begin
      if (!m_pressed) begin
        if (k && !m_prev) begin
          m_pressed = 1'b1;
          m_age     = 0;
          m_exp.p   = 1'b1;
        end
      end else begin
        m_age++;
        if (!k) begin
          m_pressed = 1'b0;
          m_exp.rl  = 1'b1;
          if (m_age <= L) begin
            m_exp.sh = 1'b1;
            m_cnt    = m_cnt + 8'd1;
          end
        end else if (m_age == L) begin
          m_exp.lg = 1'b1;
        end else if (m_age > L && R != 0 && ((m_age - L) % R) == 0) begin
          m_exp.rp = 1'b1;
        end
      end
      m_prev = k;
    end
    m_exp.hd  = m_pressed;
    m_exp.cnt = m_cnt;
  endtask

  // Apply one sample, let the DUT clock it, then compare against the model.
  task automatic step(input bit r, input bit k, input string name);
    outs_t a;
    rst_n     = r;
    key_level = k;
    @(posedge clk);
    model_edge(r, k);
    #1;
    a = dut_outs();
    obs_press += int'(a.p);
    obs_rel   += int'(a.rl);
    obs_short += int'(a.sh);
    obs_long  += int'(a.lg);
    obs_rep   += int'(a.rp);
    check(name, a, m_exp);
  endtask

  task automatic clear_obs();
    obs_press = 0; obs_rel = 0; obs_short = 0; obs_long = 0; obs_rep = 0;
  endtask

  function automatic outs_t mk(input bit p, rl, sh, lg, rp, hd, input logic [7:0] c);
    outs_t o;
    o = '{p, rl, sh, lg, rp, hd, c};
    return o;
  endfunction

  vec_t tbl[11];

  initial begin
    logic [7:0] cnt0;
    // reset with key toggling, then a 5-sample short press
    tbl[0]  = '{0, 1, mk(0,0,0,0,0,0,0)};
    tbl[1]  = '{0, 0, mk(0,0,0,0,0,0,0)};
    tbl[2]  = '{0, 1, mk(0,0,0,0,0,0,0)};
    tbl[3]  = '{1, 0, mk(0,0,0,0,0,0,0)};
    tbl[4]  = '{1, 1, mk(1,0,0,0,0,1,0)};
    tbl[5]  = '{1, 1, mk(0,0,0,0,0,1,0)};
    tbl[6]  = '{1, 1, mk(0,0,0,0,0,1,0)};
    tbl[7]  = '{1, 1, mk(0,0,0,0,0,1,0)};
    tbl[8]  = '{1, 1, mk(0,0,0,0,0,1,0)};
    tbl[9]  = '{1, 0, mk(0,1,1,0,0,0,1)};
    tbl[10] = '{1, 0, mk(0,0,0,0,0,0,1)};

    clear_obs();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst_n, tbl[i].key, $sformatf("vec%0d_model", i));
      check($sformatf("vec%0d_table", i), dut_outs(), tbl[i].exp);
    end

    // long press with repeats: high E0..E24, low at E25
    clear_obs();
    for (int i = 0; i <= 24; i++) step(1, 1, $sformatf("long_E%0d", i));
    step(1, 0, "long_release");
    check("long_counts", {obs_long[1:0], obs_rep[1:0], obs_short[1:0], obs_rel[1:0], 6'd0},
          {2'd1, 2'd3, 2'd0, 2'd1, 6'd0});
    check("long_cnt_unchanged", {6'd0, press_count}, {6'd0, 8'd1});
    step(1, 0, "gap");

    // threshold boundary: release exactly on the threshold edge is short
    clear_obs();
    for (int i = 0; i <= 9; i++) step(1, 1, $sformatf("thr_short_E%0d", i));
    step(1, 0, "thr_short_release");
    check("thr_short_counts", {obs_long[1:0], obs_short[1:0], 10'd0}, {2'd0, 2'd1, 10'd0});
    clear_obs();
    for (int i = 0; i <= 10; i++) step(1, 1, $sformatf("thr_long_E%0d", i));
    step(1, 0, "thr_long_release");
    check("thr_long_counts", {obs_long[1:0], obs_short[1:0], obs_rel[1:0], 8'd0},
          {2'd1, 2'd0, 2'd1, 8'd0});

    // key held through reset must be released before it counts
    clear_obs();
    step(0, 1, "hold_rst0");
    step(0, 1, "hold_rst1");
    for (int i = 0; i < 6; i++) step(1, 1, $sformatf("hold_after_rst%0d", i));
    check("hold_no_press", {12'd0, obs_press[1:0]}, 14'd0);
    step(1, 0, "hold_drop");
    step(1, 1, "hold_repress");
    check("hold_repress_pulse", {13'd0, press_pulse}, 14'd1);
    step(1, 0, "hold_repress_release");
    step(1, 0, "gap2");

    // 256 short presses wrap the counter back to where it started
    cnt0 = press_count;
    for (int i = 0; i < 256; i++) begin
      step(1, 1, "wrap_press");
      step(1, 0, "wrap_release");
    end
    check("wrap_count", {6'd0, press_count}, {6'd0, cnt0});

    // reset while in LONG: held clears, no release afterwards
    for (int i = 0; i <= 12; i++) step(1, 1, $sformatf("abort_E%0d", i));
    check("abort_in_long", {13'd0, held}, 14'd1);
    clear_obs();
    step(0, 1, "abort_rst");
    check("abort_held_clear", {13'd0, held}, 14'd0);
    step(1, 1, "abort_after0");
    step(1, 0, "abort_after1");
    step(1, 0, "abort_after2");
    check("abort_no_release", {12'd0, obs_rel[1:0]}, 14'd0);

    // random key activity with occasional resets
    for (int n = 0; n < 300; n++) begin
      bit k;
      int len;
      k   = bit'($urandom_range(0, 1));
      len = (k && $urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30))
                                             : int'($urandom_range(1, 12));
      for (int j = 0; j < len; j++)
        step(($urandom_range(0, 199) != 0), k, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
